hazard_scoreboard: RTL and testbench

Register-hazard scoreboard that sequences instruction issue from the decode stage against completions from the write-back stage. It tracks in-flight writes to each of the register-file entries. It withholds the issue acknowledge while a source operand is still pending (RAW) or the destination's in-flight count is saturated. It sits between ID and the register file/WB path, and uses the same 4-phase req/ack handshakes as the rest of the pipeline.

---
 rtl/hazard_scoreboard_if.sv | 35 +++
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Issue and write-back handshake bundle for hazard_scoreboard.
// The status outputs ride along with the handshakes.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned CNT_W    = 2
);
    logic                      issue_req;
    logic                      issue_ack;
    logic [ADDR_W-1:0]         issue_rs1;
    logic [ADDR_W-1:0]         issue_rs2;
    logic                      issue_use_rs1;
    logic                      issue_use_rs2;
    logic                      issue_we;
    logic [ADDR_W-1:0]         issue_rd;
    logic                      wb_req;
    logic                      wb_ack;
    logic [ADDR_W-1:0]         wb_rd;
    logic                      stall;
    logic [NUM_REGS-1:0]       busy_mask;
    logic [ADDR_W+CNT_W-1:0]   inflight;
    logic                      underflow_err;

    modport master (
        output issue_req, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_we, issue_rd, wb_req, wb_rd,
        input  issue_ack, wb_ack, stall, busy_mask, inflight, underflow_err
    );

    modport slave (
        input  issue_req, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_we, issue_rd, wb_req, wb_rd,
        output issue_ack, wb_ack, stall, busy_mask, inflight, underflow_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per-register in-flight write counters gating
// 4-phase issue handshakes, decremented by 4-phase write-back completions.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned CNT_W    = 2
) (
    input logic                 clk,
    input logic                 reset,
    hazard_scoreboard_if.slave  bus
);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic {IssueIdle, IssueAck} issue_st_e;
    typedef enum logic {WbIdle, WbAck} wb_st_e;

    issue_st_e          issue_st_q, issue_st_d;
    wb_st_e             wb_st_q, wb_st_d;
    logic [CNT_W-1:0]   cnt_q [NUM_REGS];
    logic [CNT_W-1:0]   cnt_d [NUM_REGS];
    logic               underflow_q, underflow_d;
    logic               hazard;
    logic               issue_fire;
    logic               wb_fire;

    // Hazard looks only at registered counts, so a same-edge WB cannot unblock.
    always_comb begin
        hazard = (bus.issue_use_rs1 && (cnt_q[bus.issue_rs1] != '0)) ||
                 (bus.issue_use_rs2 && (cnt_q[bus.issue_rs2] != '0)) ||
                 (bus.issue_we && (cnt_q[bus.issue_rd] == CntMax));
    end

    always_comb begin
        issue_st_d = issue_st_q;
        issue_fire = 1'b0;
        case (issue_st_q)
            IssueIdle: begin
                if (bus.issue_req && !hazard) begin
                    issue_st_d = IssueAck;
                    issue_fire = 1'b1;
                end
            end
            IssueAck: begin
                if (!bus.issue_req) issue_st_d = IssueIdle;
            end
            default: issue_st_d = IssueIdle;
        endcase
    end

    always_comb begin
        wb_st_d = wb_st_q;
        wb_fire = 1'b0;
        case (wb_st_q)
            WbIdle: begin
                if (bus.wb_req) begin
                    wb_st_d = WbAck;
                    wb_fire = 1'b1;
                end
            end
            WbAck: begin
                if (!bus.wb_req) wb_st_d = WbIdle;
            end
            default: wb_st_d = WbIdle;
        endcase
    end

    // Saturation never needs checking on increment: the hazard blocks it.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            logic inc;
            logic dec;
            inc = issue_fire && bus.issue_we && (bus.issue_rd == ADDR_W'(r));
            dec = wb_fire && (bus.wb_rd == ADDR_W'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
        underflow_d = underflow_q | (wb_fire && (cnt_q[bus.wb_rd] == '0));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_st_q  <= IssueIdle;
            wb_st_q     <= WbIdle;
            underflow_q <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            issue_st_q  <= issue_st_d;
            wb_st_q     <= wb_st_d;
            underflow_q <= underflow_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        bus.busy_mask = '0;
        bus.inflight  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            bus.busy_mask[r] = (cnt_q[r] != '0);
            bus.inflight     = bus.inflight + (ADDR_W + CNT_W)'(cnt_q[r]);
        end
    end

    assign bus.issue_ack     = (issue_st_q == IssueAck);
    assign bus.wb_ack        = (wb_st_q == WbAck);
    assign bus.underflow_err = underflow_q;
    // Gated by reset so stall reads 0 while reset is held, even before the first edge.
    assign bus.stall         = reset && bus.issue_req && (issue_st_q == IssueIdle) && hazard;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned CNT_W    = 2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    hazard_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic we, input logic [3:0] rd, input logic u1,
                             input logic [3:0] rs1, input logic u2, input logic [3:0] rs2);
        bus.issue_we      = we;
        bus.issue_rd      = rd;
        bus.issue_use_rs1 = u1;
        bus.issue_rs1     = rs1;
        bus.issue_use_rs2 = u2;
        bus.issue_rs2     = rs2;
    endtask

    // Full 4-phase issue of a write to rd with no sources; bounded waits.
    task automatic do_issue(input logic [3:0] rd);
        int n;
        set_issue(1'b1, rd, 1'b0, 4'd0, 1'b0, 4'd0);
        bus.issue_req = 1'b1;
        n = 0;
        do begin step(); n++; end while (!bus.issue_ack && n < 20);
        n_cmp++;
        if (bus.issue_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_hs_rise rd=%0d: ack=%b want 1", rd, bus.issue_ack);
        end
        bus.issue_req = 1'b0;
        n = 0;
        do begin step(); n++; end while (bus.issue_ack && n < 20);
        n_cmp++;
        if (bus.issue_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_hs_fall rd=%0d: ack=%b want 0", rd, bus.issue_ack);
        end
    endtask

    task automatic do_wb(input logic [3:0] rd);
        int n;
        bus.wb_rd  = rd;
        bus.wb_req = 1'b1;
        n = 0;
        do begin step(); n++; end while (!bus.wb_ack && n < 20);
        n_cmp++;
        if (bus.wb_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_hs_rise rd=%0d: ack=%b want 1", rd, bus.wb_ack);
        end
        bus.wb_req = 1'b0;
        n = 0;
        do begin step(); n++; end while (bus.wb_ack && n < 20);
        n_cmp++;
        if (bus.wb_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_hs_fall rd=%0d: ack=%b want 0", rd, bus.wb_ack);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.issue_req = 1'b1;
        bus.wb_req = 1'b1;
        set_issue(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        bus.wb_rd = 4'd0;
        step();
        step();
        n_cmp++; if (bus.issue_ack !== 1'b0) begin n_fail++; $display("FAIL reset_issue_ack: got %b want 0", bus.issue_ack); end
        n_cmp++; if (bus.wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wb_ack: got %b want 0", bus.wb_ack); end
        n_cmp++; if (bus.busy_mask !== 16'h0000) begin n_fail++; $display("FAIL reset_busy: got %h want 0000", bus.busy_mask); end
        n_cmp++; if (bus.inflight !== 6'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", bus.inflight); end
        n_cmp++; if (bus.underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", bus.underflow_err); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        bus.issue_req = 1'b0;
        bus.wb_req = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        set_issue(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
        bus.issue_req = 1'b1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL basic_no_stall: got %b want 0", bus.stall); end
        step();
        n_cmp++; if (bus.issue_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack_latency: got %b want 1", bus.issue_ack); end
        n_cmp++; if (bus.busy_mask !== 16'h0008) begin n_fail++; $display("FAIL basic_busy: got %h want 0008", bus.busy_mask); end
        n_cmp++; if (bus.inflight !== 6'd1) begin n_fail++; $display("FAIL basic_inflight: got %0d want 1", bus.inflight); end
        bus.issue_req = 1'b0;
        step();
        n_cmp++; if (bus.issue_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_release: got %b want 0", bus.issue_ack); end
        bus.wb_rd = 4'd3;
        bus.wb_req = 1'b1;
        step();
        n_cmp++; if (bus.wb_ack !== 1'b1) begin n_fail++; $display("FAIL basic_wb_ack: got %b want 1", bus.wb_ack); end
        n_cmp++; if (bus.busy_mask !== 16'h0000) begin n_fail++; $display("FAIL basic_wb_busy: got %h want 0000", bus.busy_mask); end
        n_cmp++; if (bus.inflight !== 6'd0) begin n_fail++; $display("FAIL basic_wb_inflight: got %0d want 0", bus.inflight); end
        bus.wb_req = 1'b0;
        step();
        n_cmp++; if (bus.wb_ack !== 1'b0) begin n_fail++; $display("FAIL basic_wb_release: got %b want 0", bus.wb_ack); end
    endtask

    task automatic test_raw();
        do_issue(4'd5);
        set_issue(1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 4'd0);
        bus.issue_req = 1'b1;
        step();
        n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.issue_ack !== 1'b0) begin n_fail++; $display("FAIL raw_ack_blocked: got %b want 0", bus.issue_ack); end
        // Same hazard through rs2 only.
        set_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5);
        step();
        n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_rs2: got %b want 1", bus.stall); end
        bus.wb_rd = 4'd5;
        bus.wb_req = 1'b1;
        step();
        n_cmp++; if (bus.issue_ack !== 1'b0) begin n_fail++; $display("FAIL raw_same_edge_wb: got %b want 0", bus.issue_ack); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL raw_stall_cleared: got %b want 0", bus.stall); end
        step();
        n_cmp++; if (bus.issue_ack !== 1'b1) begin n_fail++; $display("FAIL raw_ack_after_wb: got %b want 1", bus.issue_ack); end
        bus.issue_req = 1'b0;
        bus.wb_req = 1'b0;
        step();
        n_cmp++; if (bus.inflight !== 6'd0) begin n_fail++; $display("FAIL raw_inflight: got %0d want 0", bus.inflight); end
    endtask

    task automatic test_waw();
        do_issue(4'd7);
        do_issue(4'd7);
        do_issue(4'd7);
        n_cmp++; if (bus.inflight !== 6'd3) begin n_fail++; $display("FAIL waw_inflight3: got %0d want 3", bus.inflight); end
        n_cmp++; if (bus.busy_mask !== 16'h0080) begin n_fail++; $display("FAIL waw_busy: got %h want 0080", bus.busy_mask); end
        set_issue(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0);
        bus.issue_req = 1'b1;
        step();
        step();
        n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL waw_sat_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.issue_ack !== 1'b0) begin n_fail++; $display("FAIL waw_sat_ack: got %b want 0", bus.issue_ack); end
        bus.wb_rd = 4'd7;
        bus.wb_req = 1'b1;
        step();
        n_cmp++; if (bus.inflight !== 6'd2) begin n_fail++; $display("FAIL waw_after_wb: got %0d want 2", bus.inflight); end
        step();
        n_cmp++; if (bus.issue_ack !== 1'b1) begin n_fail++; $display("FAIL waw_unblocked: got %b want 1", bus.issue_ack); end
        n_cmp++; if (bus.inflight !== 6'd3) begin n_fail++; $display("FAIL waw_refill: got %0d want 3", bus.inflight); end
        bus.issue_req = 1'b0;
        bus.wb_req = 1'b0;
        step();
        do_wb(4'd7);
        do_wb(4'd7);
        do_wb(4'd7);
        n_cmp++; if (bus.inflight !== 6'd0) begin n_fail++; $display("FAIL waw_drained: got %0d want 0", bus.inflight); end
        n_cmp++; if (bus.underflow_err !== 1'b0) begin n_fail++; $display("FAIL waw_no_underflow: got %b want 0", bus.underflow_err); end
    endtask

    task automatic test_simultaneous();
        do_issue(4'd2);
        set_issue(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        bus.wb_rd = 4'd2;
        bus.issue_req = 1'b1;
        bus.wb_req = 1'b1;
        step();
        n_cmp++; if (bus.issue_ack !== 1'b1 || bus.wb_ack !== 1'b1) begin n_fail++; $display("FAIL simul_same_acks: got %b%b want 11", bus.issue_ack, bus.wb_ack); end
        n_cmp++; if (bus.inflight !== 6'd1) begin n_fail++; $display("FAIL simul_same_inflight: got %0d want 1", bus.inflight); end
        n_cmp++; if (bus.busy_mask !== 16'h0004) begin n_fail++; $display("FAIL simul_same_busy: got %h want 0004", bus.busy_mask); end
        bus.issue_req = 1'b0;
        bus.wb_req = 1'b0;
        step();
        set_issue(1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0);
        bus.wb_rd = 4'd2;
        bus.issue_req = 1'b1;
        bus.wb_req = 1'b1;
        step();
        n_cmp++; if (bus.busy_mask !== 16'h0010) begin n_fail++; $display("FAIL simul_diff_busy: got %h want 0010", bus.busy_mask); end
        n_cmp++; if (bus.inflight !== 6'd1) begin n_fail++; $display("FAIL simul_diff_inflight: got %0d want 1", bus.inflight); end
        bus.issue_req = 1'b0;
        bus.wb_req = 1'b0;
        step();
        do_wb(4'd4);
        n_cmp++; if (bus.busy_mask !== 16'h0000) begin n_fail++; $display("FAIL simul_drained: got %h want 0000", bus.busy_mask); end
    endtask

    task automatic test_underflow();
        bus.wb_rd = 4'd9;
        bus.wb_req = 1'b1;
        step();
        n_cmp++; if (bus.wb_ack !== 1'b1) begin n_fail++; $display("FAIL uflow_ack: got %b want 1", bus.wb_ack); end
        n_cmp++; if (bus.underflow_err !== 1'b1) begin n_fail++; $display("FAIL uflow_set: got %b want 1", bus.underflow_err); end
        n_cmp++; if (bus.inflight !== 6'd0) begin n_fail++; $display("FAIL uflow_no_wrap: got %0d want 0", bus.inflight); end
        bus.wb_req = 1'b0;
        step();
        step();
        n_cmp++; if (bus.wb_ack !== 1'b0) begin n_fail++; $display("FAIL uflow_release: got %b want 0", bus.wb_ack); end
        n_cmp++; if (bus.underflow_err !== 1'b1) begin n_fail++; $display("FAIL uflow_sticky: got %b want 1", bus.underflow_err); end
    endtask

    task automatic test_mid_reset();
        set_issue(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        bus.issue_req = 1'b1;
        step();
        n_cmp++; if (bus.issue_ack !== 1'b1) begin n_fail++; $display("FAIL mrst_pre_ack: got %b want 1", bus.issue_ack); end
        reset = 1'b0;
        step();
        n_cmp++; if (bus.issue_ack !== 1'b0) begin n_fail++; $display("FAIL mrst_ack: got %b want 0", bus.issue_ack); end
        n_cmp++; if (bus.underflow_err !== 1'b0) begin n_fail++; $display("FAIL mrst_underflow: got %b want 0", bus.underflow_err); end
        n_cmp++; if (bus.busy_mask !== 16'h0000) begin n_fail++; $display("FAIL mrst_busy: got %h want 0000", bus.busy_mask); end
        bus.issue_req = 1'b0;
        reset = 1'b1;
        step();
        do_issue(4'd6);
        n_cmp++; if (bus.busy_mask !== 16'h0040) begin n_fail++; $display("FAIL mrst_restart: got %h want 0040", bus.busy_mask); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b0;
        bus.issue_req = 1'b0;
        bus.wb_req = 1'b0;
        bus.wb_rd = 4'd0;
        set_issue(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        test_reset();
        test_basic();
        test_raw();
        test_waw();
        test_simultaneous();
        test_underflow();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
